// File: rtl/mux_result_buffer.sv
// Two-entry registered skid buffer behind the ALU operand/result mux.
// The mux word and its select tag travel together under a valid/ready handshake.
module mux_result_buffer #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [N-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    level,
  output logic [CW-1:0] xfer_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state_p0;
  logic [N-1:0]   skid_data_p0;
  logic           skid_sel_p0;
  logic           in_fire;
  logic           out_fire;

  // Handshakes use only registered flags, so there is no out_ready -> in_ready path.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Stage p0: state, main (out_*) and skid registers, delivered-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      level        <= 2'd0;
      out_data     <= '0;
      out_sel      <= 1'b0;
      skid_data_p0 <= '0;
      skid_sel_p0  <= 1'b0;
      xfer_count   <= '0;
    end else if (flush) begin
      // Handshakes coinciding with flush are dropped and not counted.
      state_p0  <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      level     <= 2'd0;
    end else begin
      if (out_fire) begin
        xfer_count <= xfer_count + CW'(1);
      end
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            out_data  <= in_data;
            out_sel   <= in_sel;
            out_valid <= 1'b1;
            level     <= 2'd1;
            state_p0  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
            out_sel  <= in_sel;
          end else if (in_fire) begin
            skid_data_p0 <= in_data;
            skid_sel_p0  <= in_sel;
            in_ready     <= 1'b0;
            level        <= 2'd2;
            state_p0     <= FULL;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            level     <= 2'd0;
            state_p0  <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_data <= skid_data_p0;
            out_sel  <= skid_sel_p0;
            in_ready <= 1'b1;
            level    <= 2'd1;
            state_p0 <= ONE;
          end
        end
        default: begin
          state_p0  <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          level     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_result_buffer.sv
// Self-checking bench for mux_result_buffer: directed vector table, streaming/wrap
// sequence, and randomized traffic against a queue-based reference model.
module tb_mux_result_buffer;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_sel, out_ready;
  logic [N-1:0]  in_data;
  logic          in_ready, out_sel, out_valid;
  logic [N-1:0]  out_data;
  logic [1:0]    level;
  logic [CW-1:0] xfer_count;

  mux_result_buffer #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered FIFO of {sel,data} limited to two entries.
  logic [N:0]   mq[$];
  logic [N-1:0] m_data;
  logic         m_sel;
  int           m_cnt;

  always @(posedge clk) begin
    bit acc, dlv;
    acc = in_valid && (mq.size() < 2);
    dlv = out_ready && (mq.size() > 0);
    if (rst) begin
      mq.delete();
      m_data = '0;
      m_sel  = 1'b0;
      m_cnt  = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (dlv) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (acc) mq.push_back({in_sel, in_data});
      if (mq.size() > 0) {m_sel, m_data} = mq[0];
    end
  end

  task automatic check_model(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
    chk({tag, " level"}, 32'(level), 32'(mq.size()));
    chk({tag, " out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, " out_sel"}, 32'(out_sel), 32'(m_sel));
    chk({tag, " xfer_count"}, 32'(xfer_count), 32'(m_cnt));
  endtask

  typedef struct {
    logic         rst, flush, iv;
    logic [N-1:0] d;
    logic         s, ordy;
    logic         e_v, e_rdy, e_sel;
    logic [N-1:0] e_d;
    logic [1:0]   e_lvl;
    int           e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [N-1:0] d,
                     input logic s, input logic ordy, input logic ev, input logic erdy,
                     input logic [N-1:0] ed, input logic esel, input logic [1:0] elvl,
                     input int ecnt);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.s = s; v.ordy = ordy;
    v.e_v = ev; v.e_rdy = erdy; v.e_d = ed; v.e_sel = esel; v.e_lvl = elvl; v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [N-1:0] d,
                       input logic s, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; in_sel = s; out_ready = ordy;
  endtask

  initial begin
    drive(1, 0, 1, 8'hAA, 0, 0);
    //   rst f iv data  s  ordy | v rdy data  sel lvl cnt
    add(1, 0, 1, 8'hAA, 0, 0,    0, 1, 8'h00, 0, 0, 0);  // reset with input offered
    add(1, 0, 1, 8'hAA, 1, 0,    0, 1, 8'h00, 0, 0, 0);
    add(0, 0, 1, 8'h11, 0, 0,    1, 1, 8'h11, 0, 1, 0);  // back-pressure fill
    add(0, 0, 1, 8'h22, 1, 0,    1, 0, 8'h11, 0, 2, 0);
    add(0, 0, 1, 8'h33, 0, 0,    1, 0, 8'h11, 0, 2, 0);  // 0x33 refused
    add(0, 0, 1, 8'h33, 0, 1,    1, 1, 8'h22, 1, 1, 1);
    add(0, 0, 1, 8'h33, 0, 1,    1, 1, 8'h33, 0, 1, 2);
    add(0, 0, 0, 8'h00, 0, 1,    0, 1, 8'h33, 0, 0, 3);
    add(0, 0, 1, 8'h44, 0, 0,    1, 1, 8'h44, 0, 1, 3);  // simultaneous in/out
    add(0, 0, 1, 8'h55, 1, 1,    1, 1, 8'h55, 1, 1, 4);
    add(0, 0, 0, 8'h00, 0, 0,    1, 1, 8'h55, 1, 1, 4);
    add(0, 0, 0, 8'h00, 0, 1,    0, 1, 8'h55, 1, 0, 5);
    add(0, 0, 1, 8'h66, 0, 0,    1, 1, 8'h66, 0, 1, 5);  // flush from FULL
    add(0, 0, 1, 8'h77, 0, 0,    1, 0, 8'h66, 0, 2, 5);
    add(0, 1, 1, 8'h88, 1, 1,    0, 1, 8'h66, 0, 0, 5);
    add(0, 0, 0, 8'h00, 0, 1,    0, 1, 8'h66, 0, 0, 5);
    add(0, 0, 1, 8'h99, 1, 0,    1, 1, 8'h99, 1, 1, 5);
    add(1, 0, 1, 8'hAB, 0, 0,    0, 1, 8'h00, 0, 0, 0);  // reset mid-transfer

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].s, vecs[i].ordy);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_v));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_d));
      chk($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("vec%0d xfer_count", i), 32'(xfer_count), 32'(vecs[i].e_cnt));
    end

    // Streaming 0x01..0x10 with out_ready held high; count starts at 0 after the reset above.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 8'(i + 1), 1'(i % 2), 1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stream%0d out_data", i), 32'(out_data), 32'(i + 1));
      chk($sformatf("stream%0d out_sel", i), 32'(out_sel), 32'(i % 2));
      chk($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d level", i), 32'(level), 32'd1);
      chk($sformatf("stream%0d xfer_count", i), 32'(xfer_count), 32'(i));
    end
    drive(0, 0, 0, 8'h00, 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("stream 16 delivered (mod 16)", 32'(xfer_count), 32'd0);
    chk("stream drained level", 32'(level), 32'd0);
    drive(0, 0, 1, 8'h5A, 0, 1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 8'h00, 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("wrap 17 delivered", 32'(xfer_count), 32'd1);
    check_model("post-wrap");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 249) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
      @(posedge clk);
      @(negedge clk);
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
